// File: rtl/mdu_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mdu_scheduler
// Purpose  : Multiply/divide sequencer for the five-stage pipeline. Accepts
//            HI/LO ops from EX and computes the 64-bit result at issue. It
//            holds the result as pending for MULT_CYCLES / DIV_CYCLES and
//            then commits it to the architectural HI/LO registers. It also
//            raises the HI/LO stall request for the D stage.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            op_E [2:0]          - 0 none,1 MULT,2 MULTU,3 DIV,4 DIVU,
//                                  5 MTHI,6 MTLO,7 none
//            rs_E, rt_E [31:0]   - forwarded operands
//            rd_hi_E             - selects HI (1) or LO (0) on md_out_E
//            md_use_D            - D-stage instruction touches HI/LO
//            md_out_E [31:0]     - combinational HI/LO read
//            busy, stall_req     - unit busy / stall request to hazard unit
//            hi, lo [31:0]       - architectural HI/LO
//            div0_flag           - sticky divide-by-zero indicator
// Config   : MDU_DIV0_FLAG_EN    - when defined, div0_flag is a real sticky
//                                  register. When undefined, it is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  op_E,
  input  logic [31:0] rs_E,
  input  logic [31:0] rt_E,
  input  logic        rd_hi_E,
  input  logic        md_use_D,
  output logic [31:0] md_out_E,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div0_flag
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [31:0] hi_nx, lo_nx;
  logic [31:0] p_hi, p_lo, p_hi_nx, p_lo_nx;
  logic        p_div0, p_div0_nx;

  logic        is_mul, is_div, is_signed;
  logic [63:0] mul_a, mul_b, mul_p;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, div_den, q_u, r_u, quo, rem;

  // Operation decode
  always_comb begin
    is_mul    = (op_E == OP_MULT) || (op_E == OP_MULTU);
    is_div    = (op_E == OP_DIV)  || (op_E == OP_DIVU);
    is_signed = (op_E == OP_MULT) || (op_E == OP_DIV);
  end

  // One 64x64 multiplier serves both flavours: sign- or zero-extending the
  // operands makes the low 64 bits of the product the correct 32x32 result.
  always_comb begin
    mul_a = {{32{is_signed & rs_E[31]}}, rs_E};
    mul_b = {{32{is_signed & rt_E[31]}}, rt_E};
    mul_p = mul_a * mul_b;
  end

  // One unsigned divider on magnitudes, with the signs restored afterwards.
  // This gives truncation toward zero and a remainder that takes the sign of
  // the dividend. A zero divisor is replaced by 1 so that no X values are
  // produced. That result is never committed.
  always_comb begin
    neg_a   = is_signed & rs_E[31];
    neg_b   = is_signed & rt_E[31];
    mag_a   = neg_a ? -rs_E : rs_E;
    mag_b   = neg_b ? -rt_E : rt_E;
    div_den = (rt_E == 32'd0) ? 32'd1 : mag_b;
    q_u     = mag_a / div_den;
    r_u     = mag_a % div_den;
    quo     = (neg_a ^ neg_b) ? -q_u : q_u;
    rem     = neg_a ? -r_u : r_u;
  end

  // Next-state logic
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    hi_nx     = hi;
    lo_nx     = lo;
    p_hi_nx   = p_hi;
    p_lo_nx   = p_lo;
    p_div0_nx = p_div0;
    case (state)
      IDLE: begin
        if (is_mul) begin
          {p_hi_nx, p_lo_nx} = mul_p;
          p_div0_nx          = 1'b0;
          cnt_nx             = MULT_LOAD;
          state_nx           = BUSY;
        end else if (is_div) begin
          p_hi_nx   = rem;
          p_lo_nx   = quo;
          p_div0_nx = (rt_E == 32'd0);
          cnt_nx    = DIV_LOAD;
          state_nx  = BUSY;
        end else if (op_E == OP_MTHI) begin
          hi_nx = rs_E;
        end else if (op_E == OP_MTLO) begin
          lo_nx = rs_E;
        end
      end
      BUSY: begin
        // New ops are ignored here. The stall keeps them out in normal flow.
        if (cnt <= 4'd1) begin
          if (!p_div0) begin
            hi_nx = p_hi;
            lo_nx = p_lo;
          end
          cnt_nx   = 4'd0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      p_hi   <= 32'd0;
      p_lo   <= 32'd0;
      p_div0 <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      hi     <= hi_nx;
      lo     <= lo_nx;
      p_hi   <= p_hi_nx;
      p_lo   <= p_lo_nx;
      p_div0 <= p_div0_nx;
    end
  end

`ifdef MDU_DIV0_FLAG_EN
  // Sticky flag. It is set when a divide by zero is issued and cleared only
  // by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      div0_flag <= 1'b0;
    end else if ((state == IDLE) && is_div && (rt_E == 32'd0)) begin
      div0_flag <= 1'b1;
    end
  end
`else
  assign div0_flag = 1'b0;
`endif

  assign busy      = (state == BUSY);
  // The stall is also raised in the issue cycle itself, before busy rises.
  assign stall_req = md_use_D & (busy | is_mul | is_div);
  assign md_out_E  = rd_hi_E ? hi : lo;

endmodule
`default_nettype wire
